// File: rtl/dsc_sn2bin.sv
// Serial stochastic/unary bitstream to binary converter.
// Counts the ones in a 2^L-bit stream, then publishes the raw count (z) and a
// NUM_BITS-wide normalized fraction (z_frac) together with a one-cycle ov pulse.
module dsc_sn2bin #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned MAX_LOG2 = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [4:0]          len_log2,
    input  logic                sn_in,
    output logic [MAX_LOG2:0]   z,
    output logic [NUM_BITS-1:0] z_frac,
    output logic                ov,
    output logic                busy
);

    localparam int unsigned CW = MAX_LOG2 + 1;
    localparam int unsigned WW = CW + NUM_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              r_state;
    logic [4:0]          r_len;
    logic [CW-1:0]       r_bits;
    logic [CW-1:0]       r_ones;
    logic [CW-1:0]       r_z;
    logic [NUM_BITS-1:0] r_z_frac;
    logic                r_ov;
    logic                r_busy;

    logic [4:0]          w_len_clamped;
    logic [CW-1:0]       w_bits_next;
    logic [CW-1:0]       w_ones_next;
    logic [CW-1:0]       w_target;
    logic                w_last;
    logic [NUM_BITS-1:0] w_frac;

    assign w_len_clamped = (32'(len_log2) > MAX_LOG2) ? 5'(MAX_LOG2) : len_log2;
    assign w_bits_next   = r_bits + CW'(1);
    assign w_ones_next   = r_ones + CW'(sn_in);
    assign w_target      = CW'(1) << r_len;
    // The bit being consumed now is the final one of the stream
    assign w_last        = (w_bits_next == w_target);

    // Scale the count to NUM_BITS: a full stream saturates, otherwise shift by |L-NUM_BITS|
    always_comb begin
        w_frac = '0;
        if (w_ones_next == w_target) begin
            w_frac = '1;
        end else if (32'(r_len) < NUM_BITS) begin
            w_frac = NUM_BITS'(WW'(w_ones_next) << (NUM_BITS - 32'(r_len)));
        end else begin
            w_frac = NUM_BITS'(WW'(w_ones_next) >> (32'(r_len) - NUM_BITS));
        end
    end

    // Control FSM with registered results and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_len    <= '0;
            r_bits   <= '0;
            r_ones   <= '0;
            r_z      <= '0;
            r_z_frac <= '0;
            r_ov     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ov <= 1'b0;
                    if (start) begin
                        r_state <= StRun;
                        r_len   <= w_len_clamped;
                        r_bits  <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (en) begin
                        r_bits <= w_bits_next;
                        r_ones <= w_ones_next;
                        if (w_last) begin
                            r_state  <= StDone;
                            r_ov     <= 1'b1;
                            r_z      <= w_ones_next;
                            r_z_frac <= w_frac;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_ov    <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_ov    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign z      = r_z;
    assign z_frac = r_z_frac;
    assign ov     = r_ov;
    assign busy   = r_busy;

endmodule

// File: tb/tb_dsc_sn2bin.sv
// Self-checking bench for dsc_sn2bin: directed vector table, reset corner cases
// and randomized streams checked against a counting/arithmetic reference model.
module tb_dsc_sn2bin;

    localparam int NB   = 8;
    localparam int MAXL = 16;

    logic            clk;
    logic            rst;
    logic            en;
    logic            start;
    logic [4:0]      len_log2;
    logic            sn_in;
    logic [MAXL:0]   z;
    logic [NB-1:0]   z_frac;
    logic            ov;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    bit stream[$];

    dsc_sn2bin #(
        .NUM_BITS(NB),
        .MAX_LOG2(MAXL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .len_log2 (len_log2),
        .sn_in    (sn_in),
        .z        (z),
        .z_frac   (z_frac),
        .ov       (ov),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lin;
        int k;
        int pat;        // 0: k ones at random positions, 1: alternating 1,0,...
        int gap_at;
        int gap_len;
        bit mid_start;
        int exp_z;
        int exp_frac;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Build a stream of n bits holding k ones
    task automatic fill_stream(input int n, input int k, input int pat);
        bit t;
        int j;
        stream = {};
        for (int i = 0; i < n; i++) begin
            if (pat == 1) stream.push_back(bit'((i % 2) == 0));
            else          stream.push_back(bit'(i < k));
        end
        if (pat == 0) begin
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = stream[i];
                stream[i] = stream[j];
                stream[j] = t;
            end
        end
    endtask

    function automatic int model_count();
        int c = 0;
        foreach (stream[i]) c += int'(stream[i]);
        return c;
    endfunction

    // Reference scaling: fraction of ones times 2^NB, floored, saturating when full
    function automatic int model_frac(input int cnt, input int lin);
        longint n;
        int l;
        l = (lin > MAXL) ? MAXL : lin;
        n = longint'(1) << l;
        if (longint'(cnt) == n) return (1 << NB) - 1;
        return int'((longint'(cnt) * (longint'(1) << NB)) / n);
    endfunction

    // One full conversion; called at a negedge, returns at a negedge
    task automatic conv(input int lin, input int gap_at, input int gap_len, input bit rnd_gaps,
                        input bit mid_start, input int exp_z, input int exp_frac,
                        input string tag);
        int l;
        int n;
        int bad;
        int g;
        l   = (lin > MAXL) ? MAXL : lin;
        n   = 1 << l;
        bad = 0;
        start    = 1'b1;
        len_log2 = lin[4:0];
        en       = 1'($urandom);
        sn_in    = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (i == gap_at) ? gap_len : 0;
            if (rnd_gaps && $urandom_range(3, 0) == 0) g += $urandom_range(2, 1);
            for (int j = 0; j < g; j++) begin
                en       = 1'b0;
                sn_in    = 1'($urandom);
                len_log2 = 5'($urandom);
                @(negedge clk);
                if (ov !== 1'b0 || busy !== 1'b1) bad++;
            end
            en    = 1'b1;
            sn_in = stream[i];
            start = mid_start && (i == n / 2);
            @(negedge clk);
            start = 1'b0;
            if (i < n - 1 && (ov !== 1'b0 || busy !== 1'b1)) bad++;
        end
        en = 1'b0;
        check($sformatf("%s_run_clean", tag), 64'(bad), 64'd0);
        check($sformatf("%s_ov", tag), 64'(ov), 64'd1);
        check($sformatf("%s_z", tag), 64'(z), 64'(exp_z));
        check($sformatf("%s_zfrac", tag), 64'(z_frac), 64'(exp_frac));
        // start during DONE must be dropped
        start = mid_start;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s_ov_pulse", tag), 64'(ov), 64'd0);
        check($sformatf("%s_busy_after", tag), 64'(busy), 64'd0);
        check($sformatf("%s_z_hold", tag), 64'(z), 64'(exp_z));
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[7];
        int   bad;
        int   lin;
        int   k;
        int   cnt;

        vecs[0] = '{lin: 4,  k: 16,    pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b0,
                    exp_z: 16,    exp_frac: 255};
        vecs[1] = '{lin: 8,  k: 100,   pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b0,
                    exp_z: 100,   exp_frac: 100};
        vecs[2] = '{lin: 2,  k: 2,     pat: 1, gap_at: 2,  gap_len: 3, mid_start: 1'b0,
                    exp_z: 2,     exp_frac: 128};
        vecs[3] = '{lin: 10, k: 300,   pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b0,
                    exp_z: 300,   exp_frac: 75};
        vecs[4] = '{lin: 0,  k: 1,     pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b0,
                    exp_z: 1,     exp_frac: 255};
        vecs[5] = '{lin: 3,  k: 0,     pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b1,
                    exp_z: 0,     exp_frac: 0};
        vecs[6] = '{lin: 31, k: 40000, pat: 0, gap_at: -1, gap_len: 0, mid_start: 1'b1,
                    exp_z: 40000, exp_frac: 156};

        rst      = 1'b1;
        start    = 1'b0;
        en       = 1'b0;
        sn_in    = 1'b0;
        len_log2 = '0;
        repeat (2) @(negedge clk);
        check("reset_z", 64'(z), 64'd0);
        check("reset_zfrac", 64'(z_frac), 64'd0);
        check("reset_ov", 64'(ov), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // No sampling until a start is accepted
        en    = 1'b1;
        sn_in = 1'b1;
        bad   = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_no_sampling", 64'(bad), 64'd0);
        en = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fill_stream(1 << ((vecs[i].lin > MAXL) ? MAXL : vecs[i].lin), vecs[i].k, vecs[i].pat);
            check($sformatf("vec%0d_model_z", i), 64'(vecs[i].exp_z), 64'(model_count()));
            conv(vecs[i].lin, vecs[i].gap_at, vecs[i].gap_len, 1'b0, vecs[i].mid_start,
                 vecs[i].exp_z, vecs[i].exp_frac, $sformatf("vec%0d", i));
        end

        // Reset in the middle of an L=4 run: abort with no ov and cleared results
        start    = 1'b1;
        len_log2 = 5'd4;
        @(negedge clk);
        start = 1'b0;
        en    = 1'b1;
        sn_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy_async", 64'(busy), 64'd0);
        check("midrst_z", 64'(z), 64'd0);
        check("midrst_ov", 64'(ov), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midrst_no_resume", 64'(bad), 64'd0);
        en = 1'b0;
        fill_stream(16, 0, 0);
        conv(4, -1, 0, 1'b0, 1'b0, 0, 0, "fresh_after_rst");

        // Randomized streams against the reference model
        for (int r = 0; r < 8; r++) begin
            lin = $urandom_range(9, 0);
            k   = $urandom_range(1 << lin, 0);
            fill_stream(1 << lin, k, 0);
            cnt = model_count();
            conv(lin, -1, 0, 1'b1, 1'($urandom), cnt, model_frac(cnt, lin),
                 $sformatf("rnd%0d_L%0d_k%0d", r, lin, k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsc_sn2bin.md
DSC_SN2BIN -- requirements
Module: dsc_sn2bin

Interface
REQ-001 Parameter NUM_BITS, default 8: width of the normalized output z_frac.
REQ-002 Parameter MAX_LOG2, default 16: largest supported stream-length exponent.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  sample enable; a stream bit is consumed only in RUN with en=1.
REQ-007 start  input  1  single-cycle request to begin a conversion; honoured only in IDLE.
REQ-008 len_log2  input  5  stream length exponent L; stream length is 2^L bits; captured at accepted start.
REQ-009 sn_in  input  1  serial stochastic/unary bitstream bit.
REQ-010 z  output  MAX_LOG2+1  count of ones in the last completed stream.
REQ-011 z_frac  output  NUM_BITS  normalized value of the last completed stream.
REQ-012 ov  output  1  one-cycle pulse marking completion; z and z_frac are valid from this cycle.
REQ-013 busy  output  1  high in RUN and DONE states.

Function
REQ-014 The FSM shall have three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on start=1. Capture L = min(len_log2, MAX_LOG2). Clear the ones counter and the bit counter.
REQ-016 In RUN, each cycle with en=1: increment the bit counter; increment the ones counter when sn_in=1.
REQ-017 In RUN with en=0, all counters shall hold; there is no timeout.
REQ-018 RUN -> DONE on the cycle that consumes bit number 2^L, including its sn_in value.
REQ-019 DONE shall last exactly one cycle: ov=1, z and z_frac updated, then -> IDLE.
REQ-020 Latency: with en held high, ov is asserted 2^L+1 cycles after the cycle in which start was sampled.
REQ-021 z shall equal the ones count, range 0..2^L inclusive, with no wrap.
REQ-022 z_frac shall be the ones count scaled by 2^NUM_BITS/2^L.
REQ-023 z_frac: when L < NUM_BITS, shift left by NUM_BITS-L; when L >= NUM_BITS, truncate by shifting right by L-NUM_BITS.
REQ-024 z_frac shall saturate to all-ones when the count equals 2^L.
REQ-025 L=0 shall be legal: a single bit is consumed; z is 0 or 1.
REQ-026 z and z_frac shall hold their values between completions; they change only in DONE.
REQ-027 start asserted in RUN or DONE shall be ignored, with no queuing.
REQ-028 start with en=0 shall still be accepted. Sampling begins at the first RUN cycle with en=1.
REQ-029 len_log2 changes after capture shall have no effect on the conversion in progress.
REQ-030 len_log2 > MAX_LOG2 shall be clamped to MAX_LOG2.

Reset
REQ-031 rst=1 shall force IDLE and clear both counters, z, z_frac, ov and busy, regardless of clock.
REQ-032 Reset mid-RUN shall abort the conversion with no ov pulse. The next conversion requires a new start.
REQ-033 After rst deasserts, no sampling shall occur until start is accepted.

Verification
REQ-034 L=4, sn_in=1 for all 16 bits, en=1 -> ov 17 cycles after start; z=16; z_frac=255.
REQ-035 L=8, sn_in high on 100 of 256 bits -> z=100, z_frac=100, one ov pulse, busy low the next cycle.
REQ-036 L=2, pattern 1,0,1,0 with en low for 3 cycles between bits 2 and 3 -> z=2, z_frac=128; ov 3 cycles later than with en held high.
REQ-037 L=10, 300 ones -> z=300, z_frac=75. L=0, sn_in=1 -> z=1, z_frac=255.
REQ-038 rst pulsed at bit 5 of an L=4 run -> no ov, z=0. A fresh start with all-zero bits gives z=0, z_frac=0.
REQ-039 start re-asserted mid-RUN, and len_log2=31 -> the second start is ignored; the length is clamped to 2^16.
